// File: rtl/cic_decim_iq.sv
// Dual-channel (I/Q) 4-stage CIC decimator with programmable ratio 1..128.
// Integrators run per input strobe, combs per decimated tick, output gain-compensated by 4*clog2(R).
module cic_decim_iq #(
    parameter int bitwidth = 16,
    parameter int stages   = 4,
    parameter int accwidth = 44
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [7:0]          rate,
    input  logic                strobe_in,
    input  logic [bitwidth-1:0] i_in,
    input  logic [bitwidth-1:0] q_in,
    output logic                strobe_out,
    output logic [bitwidth-1:0] i_out,
    output logic [bitwidth-1:0] q_out
);
    // Strobe semantics: strobe_in qualifies i_in/q_in for exactly the cycle it is high;
    // strobe_out qualifies i_out/q_out for exactly one cycle. There is no backpressure.
    typedef logic signed [accwidth-1:0] acc_t;

    function automatic logic [2:0] clog2_rate(input logic [7:0] r);
        logic [2:0] v;
        v = 3'd0;
        for (int k = 0; k < 7; k++)
            if (r > (8'd1 << k)) v = 3'(k + 1);
        return v;
    endfunction

    logic [7:0] r_eff;
    logic [6:0] reload_cnt;
    logic [6:0] cnt;
    logic [6:0] cnt_cur;
    logic [2:0] frame_log;
    logic [2:0] log_cur;
    logic [2:0] samp_log;
    logic       primed;
    logic       dec_tick;
    logic       comb_tick;
    logic       strobe_reg;
    logic       run;

    always_comb begin
        if (rate <= 8'd1)        r_eff = 8'd1;
        else if (rate > 8'd128)  r_eff = 8'd128;
        else                     r_eff = rate;
    end

    // Until the first enabled cycle after reset the counter has not been loaded,
    // so the current rate supplies both the count and the frame's shift.
    assign reload_cnt = 7'(r_eff - 8'd1);
    assign cnt_cur    = primed ? cnt : reload_cnt;
    assign log_cur    = primed ? frame_log : clog2_rate(r_eff);
    assign run        = enable & strobe_in;
    assign dec_tick   = run & (cnt_cur == 7'd0);
    assign strobe_out = strobe_reg & enable;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            primed     <= 1'b0;
            cnt        <= '0;
            frame_log  <= '0;
            samp_log   <= '0;
            comb_tick  <= 1'b0;
            strobe_reg <= 1'b0;
        end else begin
            comb_tick  <= dec_tick;
            strobe_reg <= enable & comb_tick;
            if (enable) begin
                primed <= 1'b1;
                if (strobe_in && cnt_cur == 7'd0) begin
                    cnt       <= reload_cnt;
                    frame_log <= clog2_rate(r_eff);
                    samp_log  <= log_cur;
                end else if (strobe_in) begin
                    cnt       <= cnt_cur - 7'd1;
                    frame_log <= log_cur;
                end else begin
                    cnt       <= cnt_cur;
                    frame_log <= log_cur;
                end
            end
        end
    end

    acc_t                x_ext    [2];
    acc_t                integ    [2][stages];
    acc_t                samp     [2];
    acc_t                c        [2][stages-1];
    acc_t                d        [2][stages];
    acc_t                comb_res [2];
    logic [bitwidth-1:0] out_val  [2];

    // Last comb stage is combinational into the output register, keeping strobe_out
    // two clocks after the decimating input.
    always_comb begin
        x_ext[0] = acc_t'($signed(i_in));
        x_ext[1] = acc_t'($signed(q_in));
        for (int ch = 0; ch < 2; ch++) begin
            comb_res[ch] = c[ch][stages-2] - d[ch][stages-1];
            out_val[ch]  = '0;
            for (int k = 0; k < 8; k++)
                if (samp_log == 3'(k)) out_val[ch] = comb_res[ch][stages*k +: bitwidth];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                samp[ch] <= '0;
                for (int k = 0; k < stages; k++) begin
                    integ[ch][k] <= '0;
                    d[ch][k]     <= '0;
                end
                for (int k = 0; k < stages - 1; k++) c[ch][k] <= '0;
            end
            i_out <= '0;
            q_out <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (run) begin
                    integ[ch][0] <= integ[ch][0] + x_ext[ch];
                    for (int k = 1; k < stages; k++) integ[ch][k] <= integ[ch][k] + integ[ch][k-1];
                end
                if (dec_tick) samp[ch] <= integ[ch][stages-1];
                if (enable && comb_tick) begin
                    c[ch][0] <= samp[ch] - d[ch][0];
                    d[ch][0] <= samp[ch];
                    for (int k = 1; k < stages - 1; k++) begin
                        c[ch][k] <= c[ch][k-1] - d[ch][k];
                        d[ch][k] <= c[ch][k-1];
                    end
                    d[ch][stages-1] <= c[ch][stages-2];
                end
            end
            if (enable && comb_tick) begin
                i_out <= out_val[0];
                q_out <= out_val[1];
            end
        end
    end
endmodule
